// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order memory request queue between a core and a cache
// front end. Requests are buffered in a circular FIFO and issued one at a time.
// The head entry is held until its completion. Load completions produce a
// one-cycle register writeback.
module mem_req_queue #(
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic        cpu_clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rw,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_rd,
    output logic [31:0] cpu_req_addr,
    output logic [31:0] cpu_req_data,
    output logic        cpu_req_rw,
    output logic        cpu_req_valid,
    input  logic [31:0] cpu_res_data,
    input  logic        cpu_res_ready,
    input  logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        queue_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Entry storage, one array per field
    logic        rw_mem   [DEPTH];
    logic [31:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [4:0]  rd_mem   [DEPTH];

    // Extra MSB on the pointers tells a full queue apart from an empty one
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] count_s;
    logic        full_s;
    logic        push_s;
    logic        pop_s;
    logic        head_rw_s;
    logic [4:0]  head_rd_s;

    state_t      state_r;
    logic        req_valid_r;
    logic        wb_valid_r;
    logic [4:0]  wb_rd_r;
    logic [31:0] wb_data_r;

    assign count_s   = wr_ptr_r - rd_ptr_r;
    assign full_s    = (count_s == FULL_CNT);
    assign push_s    = in_valid && !full_s;
    // Completion only counts while a request is actually outstanding
    assign pop_s     = cpu_res_ready && ((state_r == ST_ISSUE) || (state_r == ST_WAIT));
    assign head_rw_s = rw_mem[rd_ptr_r[AW-1:0]];
    assign head_rd_s = rd_mem[rd_ptr_r[AW-1:0]];

    assign in_ready      = !full_s;
    assign cpu_req_rw    = head_rw_s;
    assign cpu_req_addr  = addr_mem[rd_ptr_r[AW-1:0]];
    assign cpu_req_data  = data_mem[rd_ptr_r[AW-1:0]];
    assign cpu_req_valid = req_valid_r;
    assign wb_valid      = wb_valid_r;
    assign wb_rd         = wb_rd_r;
    assign wb_data       = wb_data_r;
    assign queue_empty   = (count_s == ZERO_CNT) && (state_r == ST_IDLE);

    // Write an accepted request into the tail slot (storage is not reset)
    always_ff @(posedge cpu_clk) begin
        if (push_s) begin
            rw_mem[wr_ptr_r[AW-1:0]]   <= in_rw;
            addr_mem[wr_ptr_r[AW-1:0]] <= in_addr;
            data_mem[wr_ptr_r[AW-1:0]] <= in_data;
            rd_mem[wr_ptr_r[AW-1:0]]   <= in_rd;
        end
    end

    // Advance tail on push and head on completion; both may happen together
    always_ff @(posedge cpu_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= ZERO_CNT;
            rd_ptr_r <= ZERO_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Issue/completion FSM with registered request pulse and writeback
    always_ff @(posedge cpu_clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            req_valid_r <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= 32'd0;
        end else begin
            req_valid_r <= 1'b0;
            wb_valid_r  <= 1'b0;
            if (pop_s && !head_rw_s) begin
                wb_valid_r <= 1'b1;
                wb_rd_r    <= head_rd_s;
                wb_data_r  <= cpu_res_data;
            end
            case (state_r)
                ST_IDLE: begin
                    if ((count_s != ZERO_CNT) && !busy) begin
                        state_r     <= ST_ISSUE;
                        req_valid_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_r <= cpu_res_ready ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (cpu_res_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed self-checking bench for mem_req_queue (DEPTH = 4).
module tb_mem_req_queue;

    logic        cpu_clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        in_rw;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_data;
    logic        cpu_req_rw;
    logic        cpu_req_valid;
    logic [31:0] cpu_res_data;
    logic        cpu_res_ready;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        queue_empty;

    int total_cnt = 0;
    int bad_cnt   = 0;

    mem_req_queue #(.DEPTH(4)) dut (
        .cpu_clk       (cpu_clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rw         (in_rw),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_rd         (in_rd),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_data  (cpu_req_data),
        .cpu_req_rw    (cpu_req_rw),
        .cpu_req_valid (cpu_req_valid),
        .cpu_res_data  (cpu_res_data),
        .cpu_res_ready (cpu_res_ready),
        .busy          (busy),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .queue_empty   (queue_empty)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic push(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd);
        in_valid = 1'b1;
        in_rw    = rw;
        in_addr  = addr;
        in_data  = data;
        in_rd    = rd;
        step();
        in_valid = 1'b0;
    endtask

    task automatic complete(input logic [31:0] data);
        cpu_res_ready = 1'b1;
        cpu_res_data  = data;
        step();
        cpu_res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},    32'(in_ready),      32'd1);
        check_eq({tag, "_qempty"},      32'(queue_empty),   32'd1);
        check_eq({tag, "_req_valid"},   32'(cpu_req_valid), 32'd0);
        check_eq({tag, "_wb_valid"},    32'(wb_valid),      32'd0);
        check_eq({tag, "_wb_rd"},       32'(wb_rd),         32'd0);
        check_eq({tag, "_wb_data"},     wb_data,            32'd0);
    endtask

    initial begin
        rstn          = 1'b0;
        in_valid      = 1'b0;
        in_rw         = 1'b0;
        in_addr       = 32'd0;
        in_data       = 32'd0;
        in_rd         = 5'd0;
        cpu_res_data  = 32'd0;
        cpu_res_ready = 1'b0;
        busy          = 1'b0;

        // Reset state
        #3;
        check_reset_outputs("rst");
        step();
        step();
        rstn = 1'b1;
        step();

        // Load 0x100 -> rd 5, issue two edges after the push
        push(1'b0, 32'h0000_0100, 32'h0, 5'd5);
        check_eq("ld_n1_valid", 32'(cpu_req_valid), 32'd0);
        step();
        check_eq("ld_n2_valid", 32'(cpu_req_valid), 32'd1);
        check_eq("ld_rw",       32'(cpu_req_rw),    32'd0);
        check_eq("ld_addr",     cpu_req_addr,       32'h0000_0100);
        check_eq("ld_qempty",   32'(queue_empty),   32'd0);
        step();
        check_eq("ld_pulse_end", 32'(cpu_req_valid), 32'd0);
        check_eq("ld_addr_hold", cpu_req_addr,       32'h0000_0100);
        complete(32'hDEAD_BEEF);
        check_eq("ld_wb_valid", 32'(wb_valid),    32'd1);
        check_eq("ld_wb_rd",    32'(wb_rd),       32'd5);
        check_eq("ld_wb_data",  wb_data,          32'hDEAD_BEEF);
        check_eq("ld_qempty2",  32'(queue_empty), 32'd1);
        step();
        check_eq("ld_wb_once",  32'(wb_valid),    32'd0);

        // Store 0x200 / 0x12345678, no writeback
        push(1'b1, 32'h0000_0200, 32'h1234_5678, 5'd0);
        step();
        check_eq("st_valid", 32'(cpu_req_valid), 32'd1);
        check_eq("st_rw",    32'(cpu_req_rw),    32'd1);
        check_eq("st_addr",  cpu_req_addr,       32'h0000_0200);
        check_eq("st_data",  cpu_req_data,       32'h1234_5678);
        step();
        check_eq("st_pulse_end", 32'(cpu_req_valid), 32'd0);
        complete(32'h0BAD_0BAD);
        check_eq("st_no_wb",  32'(wb_valid),    32'd0);
        check_eq("st_qempty", 32'(queue_empty), 32'd1);

        // Fill to DEPTH with busy held, then drain in order
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 32'h300 + 32'(i * 4), 32'h0, 5'(10 + i));
            check_eq("full_no_issue", 32'(cpu_req_valid), 32'd0);
        end
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("busy_hold", 32'(cpu_req_valid), 32'd0);
        end
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("drain_valid", 32'(cpu_req_valid), 32'd1);
            check_eq("drain_addr",  cpu_req_addr,       32'h300 + 32'(i * 4));
            step();
            if (i == 0) begin
                check_eq("full_inflight_ready", 32'(in_ready), 32'd0);
            end
            complete(32'hA0 + 32'(i));
            check_eq("drain_wb_valid", 32'(wb_valid), 32'd1);
            check_eq("drain_wb_rd",    32'(wb_rd),    32'(10 + i));
            check_eq("drain_wb_data",  wb_data,       32'hA0 + 32'(i));
            if (i == 0) begin
                check_eq("ready_after_pop", 32'(in_ready), 32'd1);
            end
        end
        check_eq("drain_qempty", 32'(queue_empty), 32'd1);

        // Push and completion on the same edge, 8 entries across pointer wrap
        busy = 1'b1;
        push(1'b0, 32'h400, 32'h0, 5'd16);
        push(1'b0, 32'h404, 32'h0, 5'd17);
        busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("wrap_valid", 32'(cpu_req_valid), 32'd1);
            check_eq("wrap_addr",  cpu_req_addr,       32'h400 + 32'(k * 4));
            step();
            if (k + 2 < 8) begin
                in_valid = 1'b1;
                in_rw    = 1'b0;
                in_addr  = 32'h400 + 32'((k + 2) * 4);
                in_rd    = 5'(16 + k + 2);
            end
            complete(32'h5000 + 32'(k));
            in_valid = 1'b0;
            check_eq("wrap_wb_valid", 32'(wb_valid), 32'd1);
            check_eq("wrap_wb_rd",    32'(wb_rd),    32'(16 + k));
            check_eq("wrap_wb_data",  wb_data,       32'h5000 + 32'(k));
            check_eq("wrap_count",    32'(dut.count_s), (k < 6) ? 32'd2 : 32'(7 - k));
        end
        check_eq("wrap_qempty", 32'(queue_empty), 32'd1);

        // Completion during ISSUE returns straight to IDLE
        push(1'b0, 32'h600, 32'h0, 5'd7);
        step();
        check_eq("iss_valid", 32'(cpu_req_valid), 32'd1);
        complete(32'hCAFE_F00D);
        check_eq("iss_wb_valid", 32'(wb_valid),      32'd1);
        check_eq("iss_wb_rd",    32'(wb_rd),         32'd7);
        check_eq("iss_wb_data",  wb_data,            32'hCAFE_F00D);
        check_eq("iss_qempty",   32'(queue_empty),   32'd1);
        check_eq("iss_req_low",  32'(cpu_req_valid), 32'd0);
        step();
        check_eq("iss_wb_once",  32'(wb_valid),      32'd0);
        check_eq("iss_no_reiss", 32'(cpu_req_valid), 32'd0);

        // Reset while waiting with 3 entries, then a stray completion
        busy = 1'b1;
        push(1'b0, 32'h700, 32'h0, 5'd1);
        push(1'b0, 32'h704, 32'h0, 5'd2);
        push(1'b0, 32'h708, 32'h0, 5'd3);
        busy = 1'b0;
        step();
        step();
        check_eq("mid_qempty", 32'(queue_empty), 32'd0);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        step();
        rstn = 1'b1;
        complete(32'h0000_0077);
        check_eq("stray_no_wb",    32'(wb_valid),      32'd0);
        check_eq("stray_qempty",   32'(queue_empty),   32'd1);
        check_eq("stray_count",    32'(dut.count_s),   32'd0);
        step();
        check_eq("stray_no_issue", 32'(cpu_req_valid), 32'd0);
        check_eq("stray_in_ready", 32'(in_ready),      32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
